text_console: RTL and testbench
===============================

Name: text_console

Overview:
Character-stream front end for the text display. The CPU pushes one byte at a time through a valid/ready handshake. The block keeps a cursor and interprets control codes. It emits single-byte writes (address, data, enable) into the 50x30 character video memory that the display engine scans out. The screen cannot be read back, so there is no scrolling: the cursor wraps to row 0, and each newly entered row is blanked first.

Parameters:
COLS, 50, characters per row (must match the scan-out stride)
ROWS, 30, rows per screen (COLS*ROWS <= 1536)
ADDR_W, 11, video memory address width
BLANK, 8'h20, fill character used for clears

Ports:
CLK_CPU  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
char_valid  input  1  char_data holds a byte to consume
char_data  input  8  ASCII byte
char_ready  output  1  block can accept a byte this cycle
video_write_enable  output  1  one-cycle write strobe to video memory
video_write_data  output  8  byte to write
video_write_addr  output  ADDR_W  target address = row*COLS + col
cursor_row  output  5  current row, 0..ROWS-1
cursor_col  output  6  current column, 0..COLS-1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset value of every output while reset=0: all outputs 0 (char_ready=0, busy=0, cursor 0/0, write outputs 0); state CLR_SCREEN, clear counter 0.
- Reset taking effect mid-operation aborts that operation; no partial-state recovery is required.
- All outputs are registered.
- States: CLR_SCREEN, IDLE, PUT, CLR_LINE.
- CLR_SCREEN:
  - Entered at reset release or on form feed.
  - Writes BLANK to addresses 0..COLS*ROWS-1 ascending, one per cycle (1500 consecutive enable cycles).
  - Then cursor=(0,0), go to IDLE.
- IDLE: char_ready=1, busy=0. A transfer occurs at a rising edge with char_valid=1 and char_ready=1. char_ready is 0 in every other state; the producer holds char_valid/char_data until accepted.
- Decode of an accepted byte:
  - 0x20..0x7E: PUT. In the next cycle, enable=1, data=byte, addr=row*COLS+col for the pre-advance cursor. Then advance: col<COLS-1 gives col+1 and IDLE; col=COLS-1 gives a newline.
  - 0x0A (LF): newline.
  - 0x0D (CR): col=0, no write, stay IDLE.
  - 0x08 (BS): col>0 gives col-1 and a PUT of BLANK at the new position; col=0 gives no change and no write.
  - 0x0C (FF): CLR_SCREEN.
  - Any other byte: discarded, no write, no cursor change.
- Newline: col=0, row = (row==ROWS-1) ? 0 : row+1. Then CLR_LINE writes BLANK to addresses newrow*COLS .. newrow*COLS+COLS-1, one per cycle, then IDLE.
- Ordering after the last-column printable: its write is issued first, then the line clear.
- Address arithmetic: row*COLS is computed without a multiplier when COLS=50, as (row<<5)+(row<<4)+(row<<1). Maximum address is 1499. No result may exceed COLS*ROWS-1.
- Cursor outputs update on the edge the state returns to IDLE (or at acceptance for CR/BS/ignored bytes).
- Throughput: printable with no wrap takes 2 cycles per byte. CR/ignored bytes take 1 cycle (ready stays high). A newline takes COLS+1 cycles including the trigger cycle.
- video_write_addr/data hold their last value when enable=0. Exactly one enable pulse occurs per written byte; there are no duplicate writes.

Test Plan:
1. Release reset -> exactly 1500 consecutive enable cycles, data 0x20, addr 0..1499 in order; then char_ready=1, cursor (0,0).
2. After init, send 'A' (0x41) -> next cycle enable=1, addr=0, data=0x41; cursor (0,1); char_ready back high 2 cycles after acceptance.
3. Fill row 0 with 50 printables, last 'Z' -> write addr 49 data 0x5A, then 50 writes of 0x20 at addr 50..99; cursor (1,0).
4. Cursor at row 29, send 0x0A -> no character write; 50 blank writes at addr 0..49; cursor (0,0). Send 0x0D at col 7 -> no write, col=0.
5. Cursor (2,3), send 0x08 -> write 0x20 at addr 102, cursor (2,2). At col 0, 0x08 -> no write, cursor unchanged. Byte 0x07 -> ignored.
6. Send 0x0C mid-session, then assert reset at the 700th clear write -> outputs go to 0 immediately. After release, a fresh full 1500-write clear runs starting at addr 0.

Source files
------------

// File: rtl/text_console.sv
// Character-stream front end: consumes CPU bytes, tracks a cursor and writes the 50x30 video memory.
// Latency: printable write appears 1 cycle after acceptance; line clear COLS cycles; screen clear COLS*ROWS cycles.
// Backpressure: char_ready is high only in IDLE; the producer holds char_valid/char_data until accepted.
module text_console #(
  parameter int          COLS   = 50,
  parameter int          ROWS   = 30,
  parameter int          ADDR_W = 11,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              CLK_CPU,
  input  logic              reset,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              video_write_enable,
  output logic [7:0]        video_write_data,
  output logic [ADDR_W-1:0] video_write_addr,
  output logic [4:0]        cursor_row,
  output logic [5:0]        cursor_col,
  output logic              busy
);

  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_END  = ADDR_W'(COLS - 1);

  typedef enum logic [1:0] {CLR_SCREEN, IDLE, PUT, CLR_LINE} state_t;

  state_t            state, nxt_state;
  logic [ADDR_W-1:0] cnt, nxt_cnt;
  logic [4:0]        row, nxt_row, row_inc;
  logic [5:0]        col, nxt_col;
  logic [7:0]        put_dat, nxt_put_dat;
  logic              put_adv, nxt_put_adv;
  logic              wr_en;
  logic [7:0]        wr_dat;
  logic [ADDR_W-1:0] wr_addr;
  logic              cur_upd;
  logic [ADDR_W-1:0] row_ext, row_base, cell_addr;

  assign row_ext = ADDR_W'(row);

  // Row base address; the 50-column case uses shift-adds instead of a multiplier.
  if (COLS == 50) begin : g_shift
    assign row_base = (row_ext << 5) + (row_ext << 4) + (row_ext << 1);
  end else begin : g_mul
    assign row_base = ADDR_W'(row_ext * COLS);
  end

  assign cell_addr = row_base + ADDR_W'(col);
  assign row_inc   = (row == LAST_ROW) ? 5'd0 : row + 5'd1;

  // Next-state decode, byte interpretation and the write request for this cycle.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_row     = row;
    nxt_col     = col;
    nxt_put_dat = put_dat;
    nxt_put_adv = put_adv;
    wr_en       = 1'b0;
    wr_dat      = BLANK;
    wr_addr     = cell_addr;
    cur_upd     = 1'b0;
    case (state)
      CLR_SCREEN: begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        if (cnt == LAST_ADDR) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
          nxt_row   = 5'd0;
          nxt_col   = 6'd0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (char_valid && char_ready) begin
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            nxt_state   = PUT;
            nxt_put_dat = char_data;
            nxt_put_adv = 1'b1;
          end else begin
            case (char_data)
              8'h0A: begin
                nxt_row   = row_inc;
                nxt_col   = 6'd0;
                nxt_cnt   = '0;
                nxt_state = CLR_LINE;
              end
              8'h0D: nxt_col = 6'd0;
              8'h08: begin
                // Backspace moves the cursor now and blanks the cell it lands on.
                if (col != 6'd0) begin
                  nxt_col     = col - 6'd1;
                  nxt_put_dat = BLANK;
                  nxt_put_adv = 1'b0;
                  nxt_state   = PUT;
                  cur_upd     = 1'b1;
                end
              end
              8'h0C: begin
                nxt_state = CLR_SCREEN;
                nxt_cnt   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        wr_en   = 1'b1;
        wr_dat  = put_dat;
        wr_addr = cell_addr;
        if (!put_adv) begin
          nxt_state = IDLE;
        end else if (col == LAST_COL) begin
          // Wrap: the character write goes out first, then the new row is blanked.
          nxt_row   = row_inc;
          nxt_col   = 6'd0;
          nxt_cnt   = '0;
          nxt_state = CLR_LINE;
        end else begin
          nxt_col   = col + 6'd1;
          nxt_state = IDLE;
        end
      end
      CLR_LINE: begin
        wr_en   = 1'b1;
        wr_addr = row_base + cnt;
        if (cnt == LINE_END) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // State, cursor and registered outputs; write address/data hold when no write is issued.
  always_ff @(posedge CLK_CPU or negedge reset) begin
    if (!reset) begin
      state              <= CLR_SCREEN;
      cnt                <= '0;
      row                <= 5'd0;
      col                <= 6'd0;
      put_dat            <= 8'd0;
      put_adv            <= 1'b0;
      char_ready         <= 1'b0;
      busy               <= 1'b0;
      video_write_enable <= 1'b0;
      video_write_data   <= 8'd0;
      video_write_addr   <= '0;
      cursor_row         <= 5'd0;
      cursor_col         <= 6'd0;
    end else begin
      state              <= nxt_state;
      cnt                <= nxt_cnt;
      row                <= nxt_row;
      col                <= nxt_col;
      put_dat            <= nxt_put_dat;
      put_adv            <= nxt_put_adv;
      char_ready         <= (nxt_state == IDLE);
      busy               <= (nxt_state != IDLE);
      video_write_enable <= wr_en;
      if (wr_en) begin
        video_write_data <= wr_dat;
        video_write_addr <= wr_addr;
      end
      if (nxt_state == IDLE || cur_upd) begin
        cursor_row <= nxt_row;
        cursor_col <= nxt_col;
      end
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: screen/line clears, printable writes, control codes, reset abort.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Every wait on char_ready is bounded; a global watchdog ends a hung run.
module tb_text_console;

  logic        CLK_CPU = 1'b0;
  logic        reset = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        video_write_enable;
  logic [7:0]  video_write_data;
  logic [10:0] video_write_addr;
  logic [4:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic        busy;

  int errors = 0;
  int checks = 0;

  text_console dut (
    .CLK_CPU            (CLK_CPU),
    .reset              (reset),
    .char_valid         (char_valid),
    .char_data          (char_data),
    .char_ready         (char_ready),
    .video_write_enable (video_write_enable),
    .video_write_data   (video_write_data),
    .video_write_addr   (video_write_addr),
    .cursor_row         (cursor_row),
    .cursor_col         (cursor_col),
    .busy               (busy)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK_CPU);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (char_ready !== 1'b1 && waited < 2000) begin
      step();
      waited++;
    end
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: char_ready=%b required 1", tag, char_ready);
    end
  endtask

  // Waits for ready, presents the byte for one acceptance edge; returns 1 unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    wait_ready("send");
    char_valid = 1'b1;
    char_data  = b;
    step();
    char_valid = 1'b0;
  endtask

  task automatic check_full_clear(input string tag);
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (video_write_enable !== 1'b1 || video_write_addr !== 11'(i) || video_write_data !== 8'h20) begin
        if (bad == 0)
          $display("FAIL %s clear_write[%0d]: en=%b addr=%0d data=%h required en=1 addr=%0d data=20",
                   tag, i, video_write_enable, video_write_addr, video_write_data, i);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    step();
    checks++;
    if (video_write_enable !== 1'b0 || video_write_addr !== 11'd1499) begin
      errors++;
      $display("FAIL %s clear_end: en=%b addr=%0d required en=0 addr=1499", tag, video_write_enable, video_write_addr);
    end
    checks++;
    if (char_ready !== 1'b1 || busy !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL %s clear_idle: ready=%b busy=%b cursor=(%0d,%0d) required ready=1 busy=0 cursor=(0,0)",
               tag, char_ready, busy, cursor_row, cursor_col);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({video_write_enable, video_write_data, video_write_addr} !== 20'd0) begin
      errors++;
      $display("FAIL reset_write_outputs: en=%b data=%h addr=%0d required all 0", video_write_enable, video_write_data, video_write_addr);
    end
    checks++;
    if ({char_ready, busy, cursor_row, cursor_col} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ctrl_outputs: ready=%b busy=%b cursor=(%0d,%0d) required all 0", char_ready, busy, cursor_row, cursor_col);
    end
    reset = 1'b1;
    check_full_clear("init");
  endtask

  task automatic test_put_a();
    send_byte(8'h41);
    checks++;
    if (char_ready !== 1'b0 || video_write_enable !== 1'b0 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL put_accept: ready=%b en=%b col=%0d required ready=0 en=0 col=0", char_ready, video_write_enable, cursor_col);
    end
    step();
    checks++;
    if (video_write_enable !== 1'b1 || video_write_addr !== 11'd0 || video_write_data !== 8'h41) begin
      errors++;
      $display("FAIL put_write: en=%b addr=%0d data=%h required en=1 addr=0 data=41", video_write_enable, video_write_addr, video_write_data);
    end
    checks++;
    if (char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 6'd1) begin
      errors++;
      $display("FAIL put_cursor: ready=%b cursor=(%0d,%0d) required ready=1 cursor=(0,1)", char_ready, cursor_row, cursor_col);
    end
    step();
    checks++;
    if (video_write_enable !== 1'b0 || video_write_addr !== 11'd0 || video_write_data !== 8'h41) begin
      errors++;
      $display("FAIL put_single_pulse: en=%b addr=%0d data=%h required en=0 addr=0 data=41", video_write_enable, video_write_addr, video_write_data);
    end
  endtask

  task automatic test_fill_row();
    int bad = 0;
    logic [7:0] ch;
    for (int c = 1; c < 49; c++) begin
      ch = 8'(8'h21 + c);
      send_byte(ch);
      step();
      if (video_write_enable !== 1'b1 || video_write_addr !== 11'(c) || video_write_data !== ch) begin
        if (bad == 0)
          $display("FAIL fill_write[%0d]: en=%b addr=%0d data=%h required en=1 addr=%0d data=%h",
                   c, video_write_enable, video_write_addr, video_write_data, c, ch);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    send_byte(8'h5A);
    step();
    checks++;
    if (video_write_enable !== 1'b1 || video_write_addr !== 11'd49 || video_write_data !== 8'h5A) begin
      errors++;
      $display("FAIL fill_last_write: en=%b addr=%0d data=%h required en=1 addr=49 data=5a", video_write_enable, video_write_addr, video_write_data);
    end
    checks++;
    if (char_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_wrap_busy: ready=%b busy=%b required ready=0 busy=1", char_ready, busy);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (video_write_enable !== 1'b1 || video_write_addr !== 11'(50 + i) || video_write_data !== 8'h20) begin
        if (bad == 0)
          $display("FAIL fill_line_clear[%0d]: en=%b addr=%0d data=%h required en=1 addr=%0d data=20",
                   i, video_write_enable, video_write_addr, video_write_data, 50 + i);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    step();
    checks++;
    if (video_write_enable !== 1'b0 || char_ready !== 1'b1 || cursor_row !== 5'd1 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL fill_end: en=%b ready=%b cursor=(%0d,%0d) required en=0 ready=1 cursor=(1,0)",
               video_write_enable, char_ready, cursor_row, cursor_col);
    end
  endtask

  task automatic test_newline_wrap();
    int bad = 0;
    repeat (28) send_byte(8'h0A);
    wait_ready("lf28");
    checks++;
    if (cursor_row !== 5'd29 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL lf_to_row29: cursor=(%0d,%0d) required (29,0)", cursor_row, cursor_col);
    end
    send_byte(8'h0A);
    checks++;
    if (video_write_enable !== 1'b0 || char_ready !== 1'b0) begin
      errors++;
      $display("FAIL lf_no_char_write: en=%b ready=%b required en=0 ready=0", video_write_enable, char_ready);
    end
    for (int i = 0; i < 50; i++) begin
      step();
      if (video_write_enable !== 1'b1 || video_write_addr !== 11'(i) || video_write_data !== 8'h20) begin
        if (bad == 0)
          $display("FAIL lf_wrap_clear[%0d]: en=%b addr=%0d data=%h required en=1 addr=%0d data=20",
                   i, video_write_enable, video_write_addr, video_write_data, i);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    step();
    checks++;
    if (video_write_enable !== 1'b0 || char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL lf_wrap_end: en=%b ready=%b cursor=(%0d,%0d) required en=0 ready=1 cursor=(0,0)",
               video_write_enable, char_ready, cursor_row, cursor_col);
    end
    for (int i = 0; i < 7; i++) begin
      send_byte(8'(8'h30 + i));
      step();
    end
    checks++;
    if (cursor_row !== 5'd0 || cursor_col !== 6'd7) begin
      errors++;
      $display("FAIL cr_setup: cursor=(%0d,%0d) required (0,7)", cursor_row, cursor_col);
    end
    send_byte(8'h0D);
    checks++;
    if (video_write_enable !== 1'b0 || char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL cr: en=%b ready=%b cursor=(%0d,%0d) required en=0 ready=1 cursor=(0,0)",
               video_write_enable, char_ready, cursor_row, cursor_col);
    end
  endtask

  task automatic test_backspace();
    send_byte(8'h0A);
    send_byte(8'h0A);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h61);
      step();
    end
    checks++;
    if (cursor_row !== 5'd2 || cursor_col !== 6'd3) begin
      errors++;
      $display("FAIL bs_setup: cursor=(%0d,%0d) required (2,3)", cursor_row, cursor_col);
    end
    send_byte(8'h08);
    checks++;
    if (cursor_row !== 5'd2 || cursor_col !== 6'd2 || char_ready !== 1'b0 || video_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL bs_accept: cursor=(%0d,%0d) ready=%b en=%b required cursor=(2,2) ready=0 en=0",
               cursor_row, cursor_col, char_ready, video_write_enable);
    end
    step();
    checks++;
    if (video_write_enable !== 1'b1 || video_write_addr !== 11'd102 || video_write_data !== 8'h20 || char_ready !== 1'b1) begin
      errors++;
      $display("FAIL bs_write: en=%b addr=%0d data=%h ready=%b required en=1 addr=102 data=20 ready=1",
               video_write_enable, video_write_addr, video_write_data, char_ready);
    end
    send_byte(8'h0D);
    send_byte(8'h08);
    checks++;
    if (video_write_enable !== 1'b0 || char_ready !== 1'b1 || cursor_row !== 5'd2 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL bs_col0_accept: en=%b ready=%b cursor=(%0d,%0d) required en=0 ready=1 cursor=(2,0)",
               video_write_enable, char_ready, cursor_row, cursor_col);
    end
    step();
    checks++;
    if (video_write_enable !== 1'b0 || char_ready !== 1'b1) begin
      errors++;
      $display("FAIL bs_col0_nowrite: en=%b ready=%b required en=0 ready=1", video_write_enable, char_ready);
    end
    send_byte(8'h07);
    step();
    checks++;
    if (video_write_enable !== 1'b0 || char_ready !== 1'b1 || cursor_row !== 5'd2 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL ignored_byte: en=%b ready=%b cursor=(%0d,%0d) required en=0 ready=1 cursor=(2,0)",
               video_write_enable, char_ready, cursor_row, cursor_col);
    end
  endtask

  task automatic test_ff_reset();
    int bad = 0;
    send_byte(8'h0C);
    checks++;
    if (char_ready !== 1'b0 || busy !== 1'b1 || video_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL ff_accept: ready=%b busy=%b en=%b required ready=0 busy=1 en=0", char_ready, busy, video_write_enable);
    end
    for (int i = 0; i < 700; i++) begin
      step();
      if (video_write_enable !== 1'b1 || video_write_addr !== 11'(i) || video_write_data !== 8'h20) begin
        if (bad == 0)
          $display("FAIL ff_clear[%0d]: en=%b addr=%0d data=%h required en=1 addr=%0d data=20",
                   i, video_write_enable, video_write_addr, video_write_data, i);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (cursor_row !== 5'd2 || cursor_col !== 6'd0) begin
      errors++;
      $display("FAIL ff_cursor_hold: cursor=(%0d,%0d) required (2,0)", cursor_row, cursor_col);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({char_ready, busy, video_write_enable, video_write_data, video_write_addr, cursor_row, cursor_col} !== 33'd0) begin
      errors++;
      $display("FAIL ff_async_reset: ready=%b busy=%b en=%b data=%h addr=%0d cursor=(%0d,%0d) required all 0",
               char_ready, busy, video_write_enable, video_write_data, video_write_addr, cursor_row, cursor_col);
    end
    step();
    step();
    reset = 1'b1;
    check_full_clear("after_reset");
  endtask

  initial begin
    test_reset();
    test_put_a();
    test_fill_row();
    test_newline_wrap();
    test_backspace();
    test_ff_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
